ascii_dec_parser: RTL and testbench

- Receive-side counterpart to the print path that turns a binary value into ASCII decimal text.
- Consumes a byte stream from the UART receiver (one-cycle `new_rx_data` strobe per byte) and parses ASCII decimal numbers terminated by LF or CR.
- Emits each parsed number as a binary value with a one-cycle valid pulse, plus overflow and syntax-error indications.
- Sits between the serial RX block and any register or command logic that takes numeric input.

---
 rtl/ascii_dec_parser.sv | 208 ++++++++++++++++++++
 tb/tb_ascii_dec_parser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ascii_dec_parser.sv
// ascii_dec_parser
// Parses ASCII decimal numbers from a UART receive byte stream. A number
// ends at LF (0x0A) or CR (0x0D), and the parsed value is presented with a
// one-cycle value_valid pulse.
//
// Optional feature: define ASCII_DEC_PARSER_SIGN_EN to accept a leading '-'
// and produce two's-complement results with signed saturation. Without it,
// '-' is an illegal character and results are unsigned.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_data      received byte, qualified by new_rx_data
//   new_rx_data  one-cycle strobe per received byte
//   value        last parsed number, held until the next value_valid
//   value_valid  one-cycle pulse, value/overflow valid
//   overflow     number exceeded range (value saturated), only with value_valid
//   error        one-cycle pulse on an illegal character
//   busy         a number is partially received (ACCUM or SKIP)
`timescale 1ns/1ps

module ascii_dec_parser #(
   parameter int WIDTH      = 32,
   parameter int MAX_DIGITS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             new_rx_data,
   output logic [WIDTH-1:0] value,
   output logic             value_valid,
   output logic             overflow,
   output logic             error,
   output logic             busy
);

`ifdef ASCII_DEC_PARSER_SIGN_EN
   localparam bit SIGN_EN = 1'b1;
`else
   localparam bit SIGN_EN = 1'b0;
`endif

   // The digit counter saturates one above MAX_DIGITS so that it never wraps.
   localparam int               CNT_W   = $clog2(MAX_DIGITS + 2);
   localparam logic [CNT_W-1:0] DIG_MAX = CNT_W'(MAX_DIGITS);
   localparam logic [CNT_W-1:0] DIG_SAT = CNT_W'(MAX_DIGITS + 1);

   // Signed magnitude limits, expressed at the width of the x10 intermediate.
   localparam logic [WIDTH+3:0] POS_LIM = {5'b00000, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH+3:0] NEG_LIM = {4'b0000, 1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, SKIP} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [CNT_W-1:0] ndig_reg, ndig_next;
   logic             ovf_reg, ovf_next;
   logic             neg_reg, neg_next;    // a '-' was seen (signed build only)
   logic             seen_reg, seen_next;  // at least one digit in this number
   logic [WIDTH-1:0] value_reg, value_next;
   logic             valid_reg, valid_next;
   logic             ovf_out_reg, ovf_out_next;
   logic             err_reg, err_next;

   // Character classification
   logic             is_digit, is_term, is_space, is_minus;
   logic [3:0]       digit_val;

   assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_term   = (rx_data == 8'h0A) || (rx_data == 8'h0D);
   assign is_space  = (rx_data == 8'h20);
   assign is_minus  = SIGN_EN && (rx_data == 8'h2D);
   assign digit_val = rx_data[3:0];

   // acc*10 + d as shift-and-add, four bits wider than the accumulator so
   // that any overshoot of the range is visible.
   logic [WIDTH+3:0] acc_ext, mul10;
   logic             ndig_inc, range_ovf, digit_ovf;
   logic [CNT_W-1:0] ndig_step;
   logic [WIDTH-1:0] result;

   assign acc_ext   = {4'b0000, acc_reg};
   assign mul10     = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, digit_val};
   // Leading zeros do not count as significant digits.
   assign ndig_inc  = (acc_reg != '0) || (digit_val != 4'd0);
   assign ndig_step = (ndig_inc && (ndig_reg != DIG_SAT)) ? ndig_reg + CNT_W'(1) : ndig_reg;
   assign digit_ovf = ndig_step > DIG_MAX;
   assign range_ovf = SIGN_EN ? (mul10 > (neg_reg ? NEG_LIM : POS_LIM))
                              : (mul10[WIDTH+3:WIDTH] != 4'd0);

   // Final value: the accumulator holds a magnitude, negated for '-' input.
   always_comb begin
      result = acc_reg;
      if (SIGN_EN) begin
         if (ovf_reg)
            result = neg_reg ? NEG_MIN : POS_MAX;
         else if (neg_reg)
            result = '0 - acc_reg;
      end else if (ovf_reg) begin
         result = '1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         acc_reg     <= '0;
         ndig_reg    <= '0;
         ovf_reg     <= 1'b0;
         neg_reg     <= 1'b0;
         seen_reg    <= 1'b0;
         value_reg   <= '0;
         valid_reg   <= 1'b0;
         ovf_out_reg <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         acc_reg     <= acc_next;
         ndig_reg    <= ndig_next;
         ovf_reg     <= ovf_next;
         neg_reg     <= neg_next;
         seen_reg    <= seen_next;
         value_reg   <= value_next;
         valid_reg   <= valid_next;
         ovf_out_reg <= ovf_out_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      acc_next     = acc_reg;
      ndig_next    = ndig_reg;
      ovf_next     = ovf_reg;
      neg_next     = neg_reg;
      seen_next    = seen_reg;
      value_next   = value_reg;
      valid_next   = 1'b0;
      ovf_out_next = 1'b0;
      err_next     = 1'b0;

      if (new_rx_data) begin
         case (state_reg)
            IDLE: begin
               if (is_digit) begin
                  acc_next   = WIDTH'(digit_val);
                  ndig_next  = (digit_val != 4'd0) ? CNT_W'(1) : '0;
                  ovf_next   = 1'b0;
                  neg_next   = 1'b0;
                  seen_next  = 1'b1;
                  state_next = ACCUM;
               end else if (is_minus) begin
                  acc_next   = '0;
                  ndig_next  = '0;
                  ovf_next   = 1'b0;
                  neg_next   = 1'b1;
                  seen_next  = 1'b0;
                  state_next = ACCUM;
               end else if (!is_space && !is_term) begin
                  err_next   = 1'b1;
                  state_next = SKIP;
               end
            end
            ACCUM: begin
               if (is_digit) begin
                  ndig_next = ndig_step;
                  seen_next = 1'b1;
                  // Overflow is sticky: the accumulator stays frozen and the
                  // remaining digits are still consumed.
                  if (ovf_reg || range_ovf || digit_ovf) begin
                     ovf_next = 1'b1;
                     acc_next = '1;
                  end else begin
                     acc_next = mul10[WIDTH-1:0];
                  end
               end else if (is_term) begin
                  state_next = IDLE;
                  if (!seen_reg) begin
                     // A lone '-' followed by a terminator
                     err_next = 1'b1;
                  end else begin
                     value_next   = result;
                     valid_next   = 1'b1;
                     ovf_out_next = ovf_reg;
                  end
               end else begin
                  err_next   = 1'b1;
                  state_next = SKIP;
               end
            end
            SKIP: begin
               if (is_term)
                  state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign value       = value_reg;
   assign value_valid = valid_reg;
   assign overflow    = ovf_out_reg;
   assign error       = err_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Testbench for ascii_dec_parser. Directed byte strings are fed in; the
// expected pulse for each terminator or bad character is queued with the
// cycle it must appear in, and a monitor process pops and compares every
// value_valid / error pulse the DUT produces.
`timescale 1ns/1ps

module tb_ascii_dec_parser;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   rx_data = 8'h00;
   logic         new_rx_data = 1'b0;
   logic [W-1:0] value;
   logic         value_valid;
   logic         overflow;
   logic         error;
   logic         busy;

   ascii_dec_parser #(.WIDTH(W), .MAX_DIGITS(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .new_rx_data (new_rx_data),
      .value       (value),
      .value_valid (value_valid),
      .overflow    (overflow),
      .error       (error),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit           is_err;
      logic [W-1:0] val;
      bit           ovf;
      int           cyc;
   } exp_t;

   typedef struct {
      int           idx;
      bit           is_err;
      logic [W-1:0] val;
      bit           ovf;
   } pend_t;

   exp_t  sb[$];
   pend_t pend[$];
   bit    chk_idle = 1'b0;
   bit    done = 1'b0;
   int    n_checks = 0;
   int    n_fail = 0;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Registers the pulse that the character at position idx of the next
   // string must produce.
   task automatic expect_at(input int idx, input bit is_err, input logic [W-1:0] val, input bit ovf);
      pend_t p;
      p.idx = idx;
      p.is_err = is_err;
      p.val = val;
      p.ovf = ovf;
      pend.push_back(p);
   endtask

   // One strobe per character, one strobe every 'gap' cycles.
   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         rx_data = s[i];
         new_rx_data = 1'b1;
         if (pend.size() > 0 && pend[0].idx == i) begin
            pend_t p;
            exp_t  e;
            p = pend.pop_front();
            e.is_err = p.is_err;
            e.val = p.val;
            e.ovf = p.ovf;
            e.cyc = cyc + 1;
            sb.push_back(e);
         end
         for (int g = 1; g < gap; g++) begin
            @(negedge clk);
            new_rx_data = 1'b0;
         end
      end
      @(negedge clk);
      new_rx_data = 1'b0;
   endtask

   // Monitor: the only process that compares and counts.
   initial begin
      logic [W-1:0] last_val;
      exp_t         e;
      last_val = '0;
      forever begin
         @(negedge clk);
         if (done) begin
            check(sb.size() == 0, "missing_pulses", 64'(sb.size()), 64'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
         end
         if (!rst_n) begin
            check({value, value_valid, overflow, error, busy} == '0, "reset_outputs",
                  64'({value, value_valid, overflow, error, busy}), 64'd0);
            last_val = '0;
         end else begin
            check(!(value_valid && error), "valid_error_exclusive", 64'({value_valid, error}), 64'd0);
            if (!value_valid)
               check(overflow == 1'b0, "overflow_unqualified", 64'(overflow), 64'd0);
            if (chk_idle)
               check(busy == 1'b0, "busy_idle", 64'(busy), 64'd0);
            if (value_valid || error) begin
               $display("cycle %0d: %s value=0x%08h overflow=%b", cyc,
                        value_valid ? "value_valid" : "error", value, overflow);
               check(sb.size() != 0, "unexpected_pulse", 64'({value_valid, error}), 64'd0);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check(error == e.is_err, "pulse_kind", 64'(error), 64'(e.is_err));
                  check(cyc == e.cyc, "pulse_latency", 64'(cyc), 64'(e.cyc));
                  if (!e.is_err) begin
                     check(value == e.val, "value", 64'(value), 64'(e.val));
                     check(overflow == e.ovf, "overflow", 64'(overflow), 64'(e.ovf));
                     last_val = e.val;
                  end
               end
            end else begin
               check(value == last_val, "value_hold", 64'(value), 64'(last_val));
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Slow strobes
      expect_at(4, 1'b0, 32'h0000_04D2, 1'b0);
      send_str("1234\n", 3);

`ifdef ASCII_DEC_PARSER_SIGN_EN
      expect_at(3, 1'b0, 32'hFFFF_FFF1, 1'b0);
      send_str("-15\n", 1);
      expect_at(11, 1'b0, 32'h8000_0000, 1'b1);
      send_str("-2147483649\n", 1);
      expect_at(1, 1'b1, '0, 1'b0);
      send_str("-\n", 1);
      expect_at(10, 1'b0, 32'h7FFF_FFFF, 1'b1);
      send_str("2147483648\n", 1);
      expect_at(11, 1'b0, 32'h8000_0000, 1'b0);
      send_str("-2147483648\n", 1);
`else
      // Unsigned range boundary, CR terminator
      expect_at(10, 1'b0, 32'hFFFF_FFFF, 1'b0);
      send_str("4294967295\015", 1);
      expect_at(10, 1'b0, 32'hFFFF_FFFF, 1'b1);
      send_str("4294967296\n", 1);
      // '-' is illegal without sign support
      expect_at(0, 1'b1, '0, 1'b0);
      send_str("-5\n", 1);
`endif

      // Illegal char mid-number, then a good number
      expect_at(2, 1'b1, '0, 1'b0);
      expect_at(7, 1'b0, 32'd55, 1'b0);
      send_str("12a4\n55\n", 1);

      // Empty lines and spaces: nothing at all
      chk_idle = 1'b1;
      send_str("\n  \015\n", 2);
      chk_idle = 1'b0;

      // Leading zeros do not count toward the digit limit
      expect_at(13, 1'b0, 32'd7, 1'b0);
      send_str("0000000000007\n", 1);

      // Only one error while skipping
      expect_at(0, 1'b1, '0, 1'b0);
      expect_at(5, 1'b0, 32'd9, 1'b0);
      send_str("x#y\n9\n", 1);

      // Space inside a number
      expect_at(1, 1'b1, '0, 1'b0);
      send_str("1 2\n", 1);

      // Terminator immediately followed by the next number
      expect_at(2, 1'b0, 32'd12, 1'b0);
      expect_at(5, 1'b0, 32'd34, 1'b0);
      send_str("12\n34\n", 1);

      // Reset in the middle of a number
      send_str("98", 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expect_at(1, 1'b0, 32'd7, 1'b0);
      send_str("7\n", 1);

      repeat (5) @(negedge clk);
      done = 1'b1;
   end

endmodule
